// File: rtl/mem_arbiter.sv
// Two-port (instruction/data cache) arbiter in front of one in-order memory port.
// Round-robin grant, ownership held until the owner's reads have all returned.
module mem_arbiter #(
    parameter int MAX_OUT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,

    input  logic [31:0] i_ic_addr,
    input  logic        i_ic_ren,
    input  logic        i_ic_wen,
    input  logic [31:0] i_ic_wdata,
    output logic        o_ic_ready,
    output logic [31:0] o_ic_rdata,
    output logic        o_ic_valid,

    input  logic [31:0] i_dc_addr,
    input  logic        i_dc_ren,
    input  logic        i_dc_wen,
    input  logic [31:0] i_dc_wdata,
    output logic        o_dc_ready,
    output logic [31:0] o_dc_rdata,
    output logic        o_dc_valid,

    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ready,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_valid,

    output logic        o_err
);

    // The outstanding counter is 3 bits wide, so MAX_OUT must stay within 1..7.
    localparam logic [2:0] MAX_CNT = 3'(MAX_OUT);

    typedef enum logic [1:0] {
        IDLE,
        OWN_IC,
        OWN_DC
    } state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic        last_gnt;
    logic        err;

    logic        ic_req;
    logic        dc_req;
    logic        sel_ic;
    logic        sel_dc;
    logic        sel_ren;
    logic        sel_wen;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        full;
    logic        fwd_ren;
    logic        fwd_wen;
    logic        grant_ready;
    logic        rd_acc;
    logic        rsp_ok;
    logic        rsp_drop;
    logic        rw_conflict;
    logic [2:0]  cnt_next;

    // In IDLE the grant is decided in the same cycle; a tie goes to the port not served last.
    always_comb begin
        ic_req = i_ic_ren | i_ic_wen;
        dc_req = i_dc_ren | i_dc_wen;
        sel_ic = 1'b0;
        sel_dc = 1'b0;
        case (state)
            OWN_IC: sel_ic = 1'b1;
            OWN_DC: sel_dc = 1'b1;
            default: begin
                if (ic_req && dc_req) begin
                    sel_ic = last_gnt;
                    sel_dc = ~last_gnt;
                end else begin
                    sel_ic = ic_req;
                    sel_dc = dc_req;
                end
            end
        endcase
    end

    always_comb begin
        sel_ren   = 1'b0;
        sel_wen   = 1'b0;
        sel_addr  = 32'h0;
        sel_wdata = 32'h0;
        if (sel_ic) begin
            sel_ren   = i_ic_ren;
            sel_wen   = i_ic_wen;
            sel_addr  = i_ic_addr;
            sel_wdata = i_ic_wdata;
        end else if (sel_dc) begin
            sel_ren   = i_dc_ren;
            sel_wen   = i_dc_wen;
            sel_addr  = i_dc_addr;
            sel_wdata = i_dc_wdata;
        end
    end

    // A simultaneous read+write is treated as a read; a full counter blocks only reads.
    always_comb begin
        full        = (cnt == MAX_CNT);
        fwd_ren     = sel_ren & ~full;
        fwd_wen     = sel_wen & ~sel_ren;
        grant_ready = i_mem_ready & ~(full & sel_ren);
        rd_acc      = fwd_ren & i_mem_ready;
        rsp_ok      = i_mem_valid & (cnt != 3'd0);
        rsp_drop    = i_mem_valid & (cnt == 3'd0);
        rw_conflict = sel_ren & sel_wen;
        case ({rd_acc, rsp_ok})
            2'b10:   cnt_next = cnt + 3'd1;
            2'b01:   cnt_next = cnt - 3'd1;
            default: cnt_next = cnt;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            last_gnt <= 1'b0;
            err      <= 1'b0;
        end else begin
            cnt <= cnt_next;
            if (rsp_drop || rw_conflict) begin
                err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (sel_ic) begin
                        state    <= OWN_IC;
                        last_gnt <= 1'b0;
                    end else if (sel_dc) begin
                        state    <= OWN_DC;
                        last_gnt <= 1'b1;
                    end
                end
                OWN_IC: begin
                    if (!ic_req && cnt_next == 3'd0) begin
                        state <= IDLE;
                    end
                end
                OWN_DC: begin
                    if (!dc_req && cnt_next == 3'd0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Every output is forced low while reset is held.
    always_comb begin
        o_mem_ren   = ~i_rst & fwd_ren;
        o_mem_wen   = ~i_rst & fwd_wen;
        o_mem_addr  = i_rst ? 32'h0 : sel_addr;
        o_mem_wdata = i_rst ? 32'h0 : sel_wdata;
        o_ic_ready  = ~i_rst & sel_ic & grant_ready;
        o_dc_ready  = ~i_rst & sel_dc & grant_ready;
        o_ic_rdata  = i_rst ? 32'h0 : i_mem_rdata;
        o_dc_rdata  = i_rst ? 32'h0 : i_mem_rdata;
        o_ic_valid  = ~i_rst & rsp_ok & (state == OWN_IC);
        o_dc_valid  = ~i_rst & rsp_ok & (state == OWN_DC);
        o_err       = ~i_rst & err;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Cycle-by-cycle directed vectors for mem_arbiter: each record holds one cycle's
// inputs and the outputs expected before the following rising edge.
module tb_mem_arbiter;

    localparam logic [1:0]  NO   = 2'b00;
    localparam logic [1:0]  RD   = 2'b10;
    localparam logic [1:0]  WR   = 2'b01;
    localparam logic [1:0]  RW   = 2'b11;
    localparam logic [1:0]  NONE = 2'b00;
    localparam logic [1:0]  P_IC = 2'b10;
    localparam logic [1:0]  P_DC = 2'b01;
    localparam logic [31:0] Z    = 32'h0;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_ic_addr, i_ic_wdata, i_dc_addr, i_dc_wdata, i_mem_rdata;
    logic        i_ic_ren, i_ic_wen, i_dc_ren, i_dc_wen, i_mem_ready, i_mem_valid;
    logic [31:0] o_ic_rdata, o_dc_rdata, o_mem_addr, o_mem_wdata;
    logic        o_ic_ready, o_ic_valid, o_dc_ready, o_dc_valid;
    logic        o_mem_ren, o_mem_wen, o_err;

    always #5 i_clk = ~i_clk;

    mem_arbiter #(.MAX_OUT(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_ic_addr(i_ic_addr), .i_ic_ren(i_ic_ren), .i_ic_wen(i_ic_wen), .i_ic_wdata(i_ic_wdata),
        .o_ic_ready(o_ic_ready), .o_ic_rdata(o_ic_rdata), .o_ic_valid(o_ic_valid),
        .i_dc_addr(i_dc_addr), .i_dc_ren(i_dc_ren), .i_dc_wen(i_dc_wen), .i_dc_wdata(i_dc_wdata),
        .o_dc_ready(o_dc_ready), .o_dc_rdata(o_dc_rdata), .o_dc_valid(o_dc_valid),
        .o_mem_addr(o_mem_addr), .o_mem_ren(o_mem_ren), .o_mem_wen(o_mem_wen), .o_mem_wdata(o_mem_wdata),
        .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata), .i_mem_valid(i_mem_valid),
        .o_err(o_err)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic [1:0]  ic_rw;
        logic [31:0] ic_addr;
        logic [1:0]  dc_rw;
        logic [31:0] dc_addr;
        logic [31:0] dc_wdata;
        logic        mem_ready;
        logic        mem_valid;
        logic [1:0]  e_rw;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [1:0]  e_rdy;
        logic [1:0]  e_vld;
        logic        e_err;
    } vec_t;

    vec_t        vecs[$];
    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] rdata_seq = 32'h5A5A_0000;

    function automatic vec_t mk(string name, logic rst,
                                logic [1:0] ic_rw, logic [31:0] ic_addr,
                                logic [1:0] dc_rw, logic [31:0] dc_addr, logic [31:0] dc_wdata,
                                logic mem_ready, logic mem_valid,
                                logic [1:0] e_rw, logic [31:0] e_addr, logic [31:0] e_wdata,
                                logic [1:0] e_rdy, logic [1:0] e_vld, logic e_err);
        vec_t v;
        v.name = name;      v.rst = rst;
        v.ic_rw = ic_rw;    v.ic_addr = ic_addr;
        v.dc_rw = dc_rw;    v.dc_addr = dc_addr;   v.dc_wdata = dc_wdata;
        v.mem_ready = mem_ready;  v.mem_valid = mem_valid;
        v.e_rw = e_rw;      v.e_addr = e_addr;     v.e_wdata = e_wdata;
        v.e_rdy = e_rdy;    v.e_vld = e_vld;       v.e_err = e_err;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(negedge i_clk);
        i_rst       = v.rst;
        {i_ic_ren, i_ic_wen} = v.ic_rw;
        i_ic_addr   = v.ic_addr;
        i_ic_wdata  = 32'h0;
        {i_dc_ren, i_dc_wen} = v.dc_rw;
        i_dc_addr   = v.dc_addr;
        i_dc_wdata  = v.dc_wdata;
        i_mem_ready = v.mem_ready;
        i_mem_valid = v.mem_valid;
        rdata_seq   = rdata_seq + 32'h0101_0101;
        i_mem_rdata = rdata_seq;
        #2;
    endtask

    task automatic checkOutput(input vec_t v);
        logic [134:0] act;
        logic [134:0] exp;
        logic [31:0]  exp_rd;
        exp_rd = v.rst ? 32'h0 : rdata_seq;
        act = {o_mem_ren, o_mem_wen, o_mem_addr, o_mem_wdata, o_ic_ready, o_dc_ready,
               o_ic_valid, o_dc_valid, o_err, o_ic_rdata, o_dc_rdata};
        exp = {v.e_rw, v.e_addr, v.e_wdata, v.e_rdy, v.e_vld, v.e_err, exp_rd, exp_rd};
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got ren/wen=%b addr=%h wdata=%h rdy=%b vld=%b err=%b rd=%h/%h, need ren/wen=%b addr=%h wdata=%h rdy=%b vld=%b err=%b rd=%h",
                     v.name, {o_mem_ren, o_mem_wen}, o_mem_addr, o_mem_wdata, {o_ic_ready, o_dc_ready},
                     {o_ic_valid, o_dc_valid}, o_err, o_ic_rdata, o_dc_rdata,
                     v.e_rw, v.e_addr, v.e_wdata, v.e_rdy, v.e_vld, v.e_err, exp_rd);
        end
    endtask

    task automatic run(input vec_t v);
        applyStimulus(v);
        checkOutput(v);
    endtask

    task automatic doReset(input string name);
        run(mk(name, 1'b1, NO, Z, NO, Z, Z, 1'b1, 1'b0, NO, Z, Z, NONE, NONE, 1'b0));
    endtask

    initial begin
        i_rst = 1'b1;
        {i_ic_ren, i_ic_wen, i_dc_ren, i_dc_wen, i_mem_ready, i_mem_valid} = '0;
        i_ic_addr = Z;  i_ic_wdata = Z;  i_dc_addr = Z;  i_dc_wdata = Z;  i_mem_rdata = Z;

        // Reset gating, DC burst to the read limit, full suppression, drain, ties, read+write.
        vecs.push_back(mk("rst_gate",  1'b1, NO, Z, RD, 32'h100, Z, 1'b1, 1'b0, NO, Z, Z, NONE, NONE, 1'b0));
        vecs.push_back(mk("rst_idle",  1'b1, NO, Z, NO, Z, Z, 1'b1, 1'b0, NO, Z, Z, NONE, NONE, 1'b0));
        vecs.push_back(mk("dc_rd0",    1'b0, NO, Z, RD, 32'h100, Z, 1'b1, 1'b0, RD, 32'h100, Z, P_DC, NONE, 1'b0));
        vecs.push_back(mk("dc_rd1",    1'b0, NO, Z, RD, 32'h104, Z, 1'b1, 1'b0, RD, 32'h104, Z, P_DC, NONE, 1'b0));
        vecs.push_back(mk("dc_rd2",    1'b0, NO, Z, RD, 32'h108, Z, 1'b1, 1'b0, RD, 32'h108, Z, P_DC, NONE, 1'b0));
        vecs.push_back(mk("dc_rd3",    1'b0, NO, Z, RD, 32'h10C, Z, 1'b1, 1'b0, RD, 32'h10C, Z, P_DC, NONE, 1'b0));
        vecs.push_back(mk("full_rsp",  1'b0, NO, Z, RD, 32'h110, Z, 1'b1, 1'b1, NO, 32'h110, Z, NONE, P_DC, 1'b0));
        vecs.push_back(mk("refill",    1'b0, NO, Z, RD, 32'h110, Z, 1'b1, 1'b0, RD, 32'h110, Z, P_DC, NONE, 1'b0));
        vecs.push_back(mk("full_hold", 1'b0, NO, Z, RD, 32'h114, Z, 1'b1, 1'b0, NO, 32'h114, Z, NONE, NONE, 1'b0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk($sformatf("drain%0d", i), 1'b0, NO, Z, NO, Z, Z, 1'b1, 1'b1, NO, Z, Z, P_DC, P_DC, 1'b0));
        vecs.push_back(mk("rst2",      1'b1, NO, Z, NO, Z, Z, 1'b1, 1'b0, NO, Z, Z, NONE, NONE, 1'b0));
        vecs.push_back(mk("tie_dc",    1'b0, RD, 32'h300, RD, 32'h400, Z, 1'b1, 1'b0, RD, 32'h400, Z, P_DC, NONE, 1'b0));
        vecs.push_back(mk("dc_rsp",    1'b0, RD, 32'h300, NO, Z, Z, 1'b1, 1'b1, NO, Z, Z, P_DC, P_DC, 1'b0));
        vecs.push_back(mk("ic_grant",  1'b0, RD, 32'h300, NO, Z, Z, 1'b1, 1'b0, RD, 32'h300, Z, P_IC, NONE, 1'b0));
        vecs.push_back(mk("ic_rsp",    1'b0, NO, Z, RD, 32'h404, Z, 1'b1, 1'b1, NO, Z, Z, P_IC, P_IC, 1'b0));
        vecs.push_back(mk("tie2_dc",   1'b0, RD, 32'h304, RD, 32'h404, Z, 1'b1, 1'b0, RD, 32'h404, Z, P_DC, NONE, 1'b0));
        vecs.push_back(mk("dc_rsp2",   1'b0, RD, 32'h304, NO, Z, Z, 1'b1, 1'b1, NO, Z, Z, P_DC, P_DC, 1'b0));
        vecs.push_back(mk("tie3_ic",   1'b0, RD, 32'h304, RD, 32'h408, Z, 1'b1, 1'b0, RD, 32'h304, Z, P_IC, NONE, 1'b0));
        vecs.push_back(mk("ic_rsp2",   1'b0, NO, Z, NO, Z, Z, 1'b1, 1'b1, NO, Z, Z, P_IC, P_IC, 1'b0));
        vecs.push_back(mk("rw_both",   1'b0, NO, Z, RW, 32'h500, 32'h1234, 1'b1, 1'b0, RD, 32'h500, 32'h1234, P_DC, NONE, 1'b0));
        vecs.push_back(mk("rw_err",    1'b0, NO, Z, NO, Z, Z, 1'b1, 1'b1, NO, Z, Z, P_DC, P_DC, 1'b1));

        for (int i = 0; i < vecs.size(); i++) begin
            run(vecs[i]);
        end

        // DC write held off while IC drains two reads, then one accepted write and release.
        doReset("b_rst");
        run(mk("b_ic_rd0",   1'b0, RD, 32'h600, NO, Z, Z, 1'b1, 1'b0, RD, 32'h600, Z, P_IC, NONE, 1'b0));
        run(mk("b_dc_wait0", 1'b0, RD, 32'h604, WR, 32'h200, 32'hDEADBEEF, 1'b1, 1'b0, RD, 32'h604, Z, P_IC, NONE, 1'b0));
        run(mk("b_dc_wait1", 1'b0, NO, Z, WR, 32'h200, 32'hDEADBEEF, 1'b1, 1'b0, NO, Z, Z, P_IC, NONE, 1'b0));
        run(mk("b_dc_wait2", 1'b0, NO, Z, WR, 32'h200, 32'hDEADBEEF, 1'b1, 1'b1, NO, Z, Z, P_IC, P_IC, 1'b0));
        run(mk("b_dc_wait3", 1'b0, NO, Z, WR, 32'h200, 32'hDEADBEEF, 1'b1, 1'b1, NO, Z, Z, P_IC, P_IC, 1'b0));
        run(mk("b_dc_wr",    1'b0, NO, Z, WR, 32'h200, 32'hDEADBEEF, 1'b1, 1'b0, WR, 32'h200, 32'hDEADBEEF, P_DC, NONE, 1'b0));
        run(mk("b_wr_done",  1'b0, NO, Z, NO, Z, Z, 1'b1, 1'b0, NO, Z, Z, P_DC, NONE, 1'b0));
        run(mk("b_release",  1'b0, RD, 32'h608, NO, Z, Z, 1'b1, 1'b0, RD, 32'h608, Z, P_IC, NONE, 1'b0));
        run(mk("b_rsp",      1'b0, NO, Z, NO, Z, Z, 1'b1, 1'b1, NO, Z, Z, P_IC, P_IC, 1'b0));

        // Memory stalls a DC read for three cycles; IC waits behind it.
        doReset("c_rst");
        run(mk("c_stall0", 1'b0, NO, Z, RD, 32'h700, Z, 1'b0, 1'b0, RD, 32'h700, Z, NONE, NONE, 1'b0));
        run(mk("c_stall1", 1'b0, RD, 32'h800, RD, 32'h700, Z, 1'b0, 1'b0, RD, 32'h700, Z, NONE, NONE, 1'b0));
        run(mk("c_stall2", 1'b0, RD, 32'h800, RD, 32'h700, Z, 1'b0, 1'b0, RD, 32'h700, Z, NONE, NONE, 1'b0));
        run(mk("c_accept", 1'b0, RD, 32'h800, RD, 32'h700, Z, 1'b1, 1'b0, RD, 32'h700, Z, P_DC, NONE, 1'b0));
        run(mk("c_rsp",    1'b0, RD, 32'h800, NO, Z, Z, 1'b1, 1'b1, NO, Z, Z, P_DC, P_DC, 1'b0));
        run(mk("c_ic",     1'b0, RD, 32'h800, NO, Z, Z, 1'b1, 1'b0, RD, 32'h800, Z, P_IC, NONE, 1'b0));

        // Reset with three reads in flight; their late responses are dropped and flagged.
        doReset("d_rst0");
        run(mk("d_rd0",   1'b0, NO, Z, RD, 32'h900, Z, 1'b1, 1'b0, RD, 32'h900, Z, P_DC, NONE, 1'b0));
        run(mk("d_rd1",   1'b0, NO, Z, RD, 32'h904, Z, 1'b1, 1'b0, RD, 32'h904, Z, P_DC, NONE, 1'b0));
        run(mk("d_rd2",   1'b0, NO, Z, RD, 32'h908, Z, 1'b1, 1'b0, RD, 32'h908, Z, P_DC, NONE, 1'b0));
        doReset("d_rst1");
        run(mk("d_drop0", 1'b0, NO, Z, NO, Z, Z, 1'b1, 1'b1, NO, Z, Z, NONE, NONE, 1'b0));
        run(mk("d_drop1", 1'b0, NO, Z, NO, Z, Z, 1'b1, 1'b1, NO, Z, Z, NONE, NONE, 1'b1));
        run(mk("d_drop2", 1'b0, NO, Z, NO, Z, Z, 1'b1, 1'b1, NO, Z, Z, NONE, NONE, 1'b1));
        run(mk("d_new",   1'b0, NO, Z, RD, 32'h90C, Z, 1'b1, 1'b0, RD, 32'h90C, Z, P_DC, NONE, 1'b1));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUT, default 4: maximum accepted-but-unanswered reads.
REQ-002 SHALL have ports (name direction width meaning):
- i_clk in 1: clock; reset i_rst, synchronous, active-high.
- i_rst in 1: synchronous active-high reset.
- i_ic_addr in 32, i_ic_ren in 1, i_ic_wen in 1, i_ic_wdata in 32: instruction-cache request (port 0).
- o_ic_ready out 1, o_ic_rdata out 32, o_ic_valid out 1: port-0 accept and read response.
- i_dc_addr in 32, i_dc_ren in 1, i_dc_wen in 1, i_dc_wdata in 32: data-cache request (port 1).
- o_dc_ready out 1, o_dc_rdata out 32, o_dc_valid out 1: port-1 accept and read response.
- o_mem_addr out 32, o_mem_ren out 1, o_mem_wen out 1, o_mem_wdata out 32: shared memory request.
- i_mem_ready in 1, i_mem_rdata in 32, i_mem_valid in 1: memory accept and in-order read response.
- o_err out 1: sticky protocol-error flag.

Function
REQ-003 SHALL count a request as accepted in a cycle when forwarded ren or wen is high and i_mem_ready is high.
REQ-004 SHALL implement states IDLE, OWN_IC, OWN_DC.
REQ-005 In IDLE, SHALL arbitrate combinationally in the same cycle: a single requester is granted; if both request, grant the port not granted last (round-robin bit last_gnt, reset value 0 meaning IC last, so DC wins the first tie).
REQ-006 The granted port's addr/ren/wen/wdata SHALL drive o_mem_* combinationally; o_<port>_ready = i_mem_ready for the owner; non-owner ready SHALL be 0.
REQ-007 With no owner and no request, o_mem_ren=0, o_mem_wen=0, o_mem_addr=0, o_mem_wdata=0.
REQ-008 From IDLE, SHALL enter OWN_IC/OWN_DC on the cycle the granted port asserts a request (accepted or not) and update last_gnt.
REQ-009 SHALL keep a 3-bit outstanding counter: +1 on accepted read, -1 on i_mem_valid, unchanged when both occur in one cycle.
REQ-010 When counter == MAX_OUT, SHALL suppress forwarded ren (owner ready 0); writes still pass.
REQ-011 Owner SHALL be retained while it asserts ren/wen or counter (after this cycle's update) is nonzero.
REQ-012 SHALL return to IDLE when owner has no request and the next counter value is 0; the other port may be granted on the following cycle.
REQ-013 i_mem_rdata SHALL drive both o_ic_rdata and o_dc_rdata; i_mem_valid SHALL route only to the owner's valid, the other valid 0.
REQ-014 i_mem_valid with counter 0 SHALL be dropped (no valid out, counter stays 0) and set o_err.
REQ-015 A port asserting ren and wen together while granted SHALL forward ren only, suppress wen, and set o_err.
REQ-016 Non-owner requests SHALL be held off (ready 0) with no side effects; no request is lost or duplicated.
REQ-017 Write requests SHALL not change the counter; a write-only ownership releases the cycle after its accepted write if no further request.

Reset
REQ-018 On i_rst: state IDLE, counter 0, last_gnt 0, o_err 0; all outputs 0 while i_rst is high.
REQ-019 Responses to pre-reset reads arriving after reset SHALL be dropped per REQ-014 (o_err set).

Verification
REQ-020 DC reads 0x100..0x10C (4 back-to-back, ready=1), IC idle -> o_mem_addr sequence 0x100,0x104,0x108,0x10C, counter reaches 4, 4 o_dc_valid pulses, o_ic_valid never, IDLE after last valid.
REQ-021 IC and DC request same cycle from reset -> DC granted first; after DC drains, IC granted; next tie -> DC (alternation).
REQ-022 IC owns with 2 reads outstanding, DC issues write 0x200 data 0xDEADBEEF -> o_dc_ready 0 until IC counter 0, then o_mem_wen=1, addr 0x200, wdata 0xDEADBEEF for exactly one accepted cycle.
REQ-023 i_mem_ready=0 for 3 cycles during DC read -> request held, counter unchanged, ownership kept; accepted on cycle ready rises.
REQ-024 Counter=4, new ren plus simultaneous i_mem_valid -> ren suppressed that cycle, counter 3; next cycle ren accepted, counter 4.
REQ-025 Reset asserted with 3 reads outstanding, then 3 i_mem_valid pulses -> no valid to either port, counter 0, o_err=1 after first pulse.
